// File: rtl/display_serializer_pkg.sv
// Shared segment codes, FSM state encoding and BCD to 7-segment lookup
// for the display serializer.
package display_serializer_pkg;

  localparam logic [7:0] SEG_0     = 8'hFC;
  localparam logic [7:0] SEG_1     = 8'h60;
  localparam logic [7:0] SEG_2     = 8'hDA;
  localparam logic [7:0] SEG_3     = 8'hF2;
  localparam logic [7:0] SEG_4     = 8'h66;
  localparam logic [7:0] SEG_5     = 8'hB6;
  localparam logic [7:0] SEG_6     = 8'hBE;
  localparam logic [7:0] SEG_7     = 8'hE0;
  localparam logic [7:0] SEG_8     = 8'hFE;
  localparam logic [7:0] SEG_9     = 8'hF6;
  localparam logic [7:0] SEG_DASH  = 8'h02;
  localparam logic [7:0] SEG_BLANK = 8'h00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_LATCH,
    ST_GAP
  } state_t;

  // Segment code {a,b,c,d,e,f,g,dp} with dp cleared; non-decimal codes show a dash.
  function automatic logic [7:0] bcd2seg(input logic [3:0] bcd);
    logic [7:0] seg;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/display_serializer_encoder.sv
// Combinational frame encoder: BCD digits plus decimal points to segment
// codes, with optional leading-zero blanking.
module seg_frame_encoder
  import display_serializer_pkg::*;
#(
  parameter int unsigned DIGITS = 4
) (
  input  logic [4*DIGITS-1:0] bcd_in,
  input  logic [DIGITS-1:0]   dp_in,
  input  logic                blank_lz,
  output logic [8*DIGITS-1:0] frame_c
);

  // Walk from the most significant digit; blanking stops at the first nonzero digit.
  always_comb begin
    logic lz;
    frame_c = '0;
    lz      = blank_lz;
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      if (lz && (i != 0) && (bcd_in[4*i +: 4] == 4'd0)) begin
        frame_c[8*i +: 8] = SEG_BLANK | {7'd0, dp_in[i]};
      end else begin
        lz                = 1'b0;
        frame_c[8*i +: 8] = bcd2seg(bcd_in[4*i +: 4]) | {7'd0, dp_in[i]};
      end
    end
  end

endmodule

// File: rtl/display_serializer.sv
// Serial sender for a multi-digit 7-segment display: encodes a frame, shifts
// it out on sclk/sdata, pulses latch, then idles for a configurable gap.
module display_serializer
  import display_serializer_pkg::*;
#(
  parameter int unsigned DIGITS       = 4,
  parameter int unsigned CLK_DIV      = 50,
  parameter int unsigned GAP_BITS     = 3,
  parameter bit          LSB_FIRST    = 1'b1,
  parameter bit          AUTO_REFRESH = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [4*DIGITS-1:0] bcd_in,
  input  logic [DIGITS-1:0]   dp_in,
  input  logic                blank_lz,
  input  logic                update_req,
  output logic                sclk,
  output logic                sdata,
  output logic                latch,
  output logic                busy,
  output logic                frame_done
);

  localparam int unsigned FRAME_BITS = 8 * DIGITS;
  localparam int unsigned DIV_MAX    = 2 * CLK_DIV - 1;
  localparam int unsigned DIV_W      = $clog2(DIV_MAX + 1);
  localparam int unsigned CNT_MAX    = ((FRAME_BITS > GAP_BITS) ? FRAME_BITS : GAP_BITS) - 1;
  localparam int unsigned CNT_W      = $clog2(CNT_MAX + 1);
  localparam int unsigned GAP_LAST   = (GAP_BITS == 0) ? 0 : GAP_BITS - 1;

  state_t                  state;
  logic [DIV_W-1:0]        div;
  logic [CNT_W-1:0]        bit_cnt;
  logic [FRAME_BITS-1:0]   shreg;
  logic                    pending;

  logic [FRAME_BITS-1:0]   frame_c;
  logic [FRAME_BITS-1:0]   shreg_nxt_c;
  logic                    first_bit_c;
  logic                    next_bit_c;
  logic                    div_end_c;
  logic                    req_c;
  logic                    again_c;

  seg_frame_encoder #(
    .DIGITS (DIGITS)
  ) u_encoder (
    .bcd_in   (bcd_in),
    .dp_in    (dp_in),
    .blank_lz (blank_lz),
    .frame_c  (frame_c)
  );

  assign shreg_nxt_c = LSB_FIRST ? (shreg >> 1) : (shreg << 1);
  assign first_bit_c = LSB_FIRST ? frame_c[0] : frame_c[FRAME_BITS-1];
  assign next_bit_c  = LSB_FIRST ? shreg_nxt_c[0] : shreg_nxt_c[FRAME_BITS-1];
  assign div_end_c   = (div == DIV_W'(DIV_MAX));
  assign req_c       = update_req && !AUTO_REFRESH;
  assign again_c     = AUTO_REFRESH || pending || update_req;

  // Frame sequencer, sclk divider, bit/gap counter and shift register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ST_IDLE;
      div        <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      pending    <= 1'b0;
      sclk       <= 1'b0;
      sdata      <= 1'b0;
      latch      <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          sclk  <= 1'b0;
          sdata <= 1'b0;
          latch <= 1'b0;
          if (AUTO_REFRESH || update_req) begin
            state   <= ST_LOAD;
            busy    <= 1'b1;
            pending <= 1'b0;
          end else begin
            busy <= 1'b0;
          end
        end

        ST_LOAD: begin
          shreg   <= frame_c;
          sdata   <= first_bit_c;
          sclk    <= 1'b0;
          div     <= '0;
          bit_cnt <= '0;
          state   <= ST_SHIFT;
        end

        ST_SHIFT: begin
          if (req_c) pending <= 1'b1;
          if (div_end_c) begin
            div  <= '0;
            sclk <= 1'b0;
            if (bit_cnt == CNT_W'(FRAME_BITS - 1)) begin
              bit_cnt <= '0;
              sdata   <= 1'b0;
              latch   <= 1'b1;
              state   <= ST_LATCH;
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
              shreg   <= shreg_nxt_c;
              sdata   <= next_bit_c;
            end
          end else begin
            div  <= div + DIV_W'(1);
            sclk <= (div >= DIV_W'(CLK_DIV - 1));
          end
        end

        ST_LATCH: begin
          if (req_c) pending <= 1'b1;
          if (div == DIV_W'(DIV_MAX - 1)) frame_done <= 1'b1;
          if (div_end_c) begin
            div   <= '0;
            latch <= 1'b0;
            if (GAP_BITS != 0) begin
              state <= ST_GAP;
            end else if (again_c) begin
              state   <= ST_LOAD;
              pending <= 1'b0;
            end else begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end else begin
            div <= div + DIV_W'(1);
          end
        end

        ST_GAP: begin
          if (req_c) pending <= 1'b1;
          if (div_end_c) begin
            div <= '0;
            if (bit_cnt == CNT_W'(GAP_LAST)) begin
              bit_cnt <= '0;
              if (again_c) begin
                state   <= ST_LOAD;
                pending <= 1'b0;
              end else begin
                state <= ST_IDLE;
                busy  <= 1'b0;
              end
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end else begin
            div <= div + DIV_W'(1);
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
